seq_functional_unit: RTL and testbench

SEQ_FUNCTIONAL_UNIT -- requirements
Module: seq_functional_unit

---
 rtl/seq_functional_unit.sv | 155 +++++++++++++++
 tb/tb_seq_functional_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_functional_unit.sv
// Multi-cycle functional unit: single-cycle ALU ops plus a bit-serial logical shifter.
// One request is accepted in IDLE; the result is registered with its flags and flagged by a one-cycle out_valid.
module seq_functional_unit #(
   parameter int nBit = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      FS,
   input  logic [nBit-1:0] A,
   input  logic [nBit-1:0] B,
   output logic            out_valid,
   output logic [nBit-1:0] out,
   output logic            zero_flag,
   output logic            carry_flag,
   output logic            ovf_flag
);

   // Shift-amount width is tied to the datapath width.
   localparam int SHW = $clog2(nBit);
   localparam int MSB = nBit - 1;
   localparam logic [SHW-1:0] AMT_ONE = SHW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_reg;
   logic [nBit-1:0] work_reg;
   logic [SHW-1:0]  cnt_reg;
   logic            dir_reg;
   logic [nBit-1:0] out_reg;
   logic            zero_reg;
   logic            carry_reg;
   logic            ovf_reg;
   logic            valid_reg;
   logic            ready_reg;

   logic [SHW-1:0]  amt;
   logic            go_shift;
   logic [nBit:0]   sum_ext;
   logic [nBit:0]   diff_ext;
   logic [nBit-1:0] a_step;
   logic [nBit-1:0] work_step;
   logic [nBit-1:0] imm_res_next;
   logic            imm_carry_next;
   logic            imm_ovf_next;

   function automatic logic [nBit-1:0] shift1(input logic [nBit-1:0] v, input logic right);
      return right ? {1'b0, v[nBit-1:1]} : {v[nBit-2:0], 1'b0};
   endfunction

   assign amt       = B[SHW-1:0];
   assign sum_ext   = {1'b0, A} + {1'b0, B};
   assign diff_ext  = {1'b0, A} + {1'b0, ~B} + {{nBit{1'b0}}, 1'b1};
   assign a_step    = shift1(A, FS[0]);
   assign work_step = shift1(work_reg, dir_reg);
   // Shifts of 0 or 1 finish straight from IDLE; longer ones need the SHIFT state.
   assign go_shift  = FS[2] & FS[1] & (amt > AMT_ONE);

   always_comb begin
      imm_res_next   = '0;
      imm_carry_next = 1'b0;
      imm_ovf_next   = 1'b0;
      case (FS)
         3'b000: begin
            imm_res_next   = sum_ext[nBit-1:0];
            imm_carry_next = sum_ext[nBit];
            imm_ovf_next   = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
         end
         3'b001: begin
            imm_res_next   = diff_ext[nBit-1:0];
            imm_carry_next = diff_ext[nBit];
            imm_ovf_next   = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
         end
         3'b010:  imm_res_next = A & B;
         3'b011:  imm_res_next = A | B;
         3'b100:  imm_res_next = A ^ B;
         3'b101:  imm_res_next = {{(nBit-1){1'b0}}, ($signed(A) < $signed(B))};
         default: imm_res_next = (amt == '0) ? A : a_step;
      endcase
   end

   // The first shift step is taken on the acceptance edge so a k-bit shift
   // reports its result exactly k cycles after acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         work_reg  <= '0;
         cnt_reg   <= '0;
         dir_reg   <= 1'b0;
         out_reg   <= '0;
         zero_reg  <= 1'b0;
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         valid_reg <= 1'b0;
         ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            S_IDLE: begin
               valid_reg <= 1'b0;
               if (in_valid) begin
                  ready_reg <= 1'b0;
                  if (go_shift) begin
                     work_reg  <= a_step;
                     cnt_reg   <= amt - AMT_ONE;
                     dir_reg   <= FS[0];
                     state_reg <= S_SHIFT;
                  end else begin
                     out_reg   <= imm_res_next;
                     zero_reg  <= (imm_res_next == '0);
                     carry_reg <= imm_carry_next;
                     ovf_reg   <= imm_ovf_next;
                     valid_reg <= 1'b1;
                     state_reg <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               work_reg <= work_step;
               cnt_reg  <= cnt_reg - AMT_ONE;
               if (cnt_reg == AMT_ONE) begin
                  out_reg   <= work_step;
                  zero_reg  <= (work_step == '0);
                  carry_reg <= 1'b0;
                  ovf_reg   <= 1'b0;
                  valid_reg <= 1'b1;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               valid_reg <= 1'b0;
               ready_reg <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: begin
               valid_reg <= 1'b0;
               ready_reg <= 1'b1;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = ready_reg;
   assign out_valid  = valid_reg;
   assign out        = out_reg;
   assign zero_flag  = zero_reg;
   assign carry_flag = carry_reg;
   assign ovf_flag   = ovf_reg;

endmodule

// File: tb/tb_seq_functional_unit.sv
// Bench for seq_functional_unit: directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_seq_functional_unit;

   localparam int NB = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    FS;
   logic [NB-1:0] A;
   logic [NB-1:0] B;
   logic          out_valid;
   logic [NB-1:0] out;
   logic          zero_flag;
   logic          carry_flag;
   logic          ovf_flag;

   int n_pass  = 0;
   int n_total = 0;

   seq_functional_unit #(.nBit(NB)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .FS         (FS),
      .A          (A),
      .B          (B),
      .out_valid  (out_valid),
      .out        (out),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .ovf_flag   (ovf_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    fs;
      logic [NB-1:0] a;
      logic [NB-1:0] b;
      logic [NB-1:0] e_out;
      logic          e_z;
      logic          e_c;
      logic          e_v;
      int            e_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model straight from the operation definitions, using 32-bit integers.
   task automatic ref_model(input logic [2:0] fs, input logic [NB-1:0] a, input logic [NB-1:0] b,
                            output logic [NB-1:0] o, output logic z, output logic c,
                            output logic v, output int lat);
      int unsigned ua, ub, k, r;
      int sa, sb, s;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      k = ub % NB;
      c = 1'b0; v = 1'b0; r = 0;
      case (fs)
         3'd0: begin r = ua + ub; c = (r >= 65536); s = sa + sb; v = (s > 32767) || (s < -32768); end
         3'd1: begin r = ua - ub; c = (ua >= ub);   s = sa - sb; v = (s > 32767) || (s < -32768); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = (sa < sb) ? 1 : 0;
         3'd6: r = ua << k;
         default: r = ua >> k;
      endcase
      o   = r[NB-1:0];
      z   = (o == 0);
      lat = (fs >= 3'd6 && k > 0) ? int'(k) : 1;
   endtask

   // Called at a negedge; returns at the negedge of the out_valid cycle.
   task automatic do_op(input logic [2:0] fs, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        output logic [NB-1:0] o, output logic z, output logic c,
                        output logic v, output int lat);
      int g;
      g = 0;
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      FS = fs; A = a; B = b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom); FS = 3'($urandom);
      lat = 41;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      o = out; z = zero_flag; c = carry_flag; v = ovf_flag;
      $display("op fs=%0d a=%h b=%h -> out=%h z=%b c=%b v=%b lat=%0d", fs, a, b, o, z, c, v, lat);
   endtask

   task automatic run_and_check(input string tag, input logic [2:0] fs, input logic [NB-1:0] a,
                                input logic [NB-1:0] b, input logic [NB-1:0] e_out, input logic e_z,
                                input logic e_c, input logic e_v, input int e_lat);
      logic [NB-1:0] o;
      logic z, c, v;
      int lat;
      do_op(fs, a, b, o, z, c, v, lat);
      check({tag, ".lat"}, lat, e_lat);
      check({tag, ".out"}, o, e_out);
      check({tag, ".zero"}, z, e_z);
      check({tag, ".carry"}, c, e_c);
      check({tag, ".ovf"}, v, e_v);
      @(negedge clk);
      check({tag, ".pulse_end"}, out_valid, 1'b0);
      check({tag, ".ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      vec_t vt[16];
      logic [NB-1:0] e_o, got;
      logic e_z, e_c, e_v;
      int e_lat, pulses;
      logic [2:0] rfs;
      logic [NB-1:0] ra, rb;

      vt[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 1};
      vt[1]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1, 1};
      vt[2]  = '{3'd5, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 1};
      vt[3]  = '{3'd6, 16'h0001, 16'h000F, 16'h8000, 0, 0, 0, 15};
      vt[4]  = '{3'd7, 16'h8000, 16'h0013, 16'h1000, 0, 0, 0, 3};
      vt[5]  = '{3'd6, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 1};
      vt[6]  = '{3'd7, 16'h1234, 16'hFFF0, 16'h1234, 0, 0, 0, 1};
      vt[7]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1};
      vt[8]  = '{3'd1, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 0, 1};
      vt[9]  = '{3'd1, 16'h5555, 16'h5555, 16'h0000, 1, 1, 0, 1};
      vt[10] = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 1};
      vt[11] = '{3'd3, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0, 1};
      vt[12] = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 1};
      vt[13] = '{3'd5, 16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0, 1};
      vt[14] = '{3'd6, 16'h0003, 16'h0001, 16'h0006, 0, 0, 0, 1};
      vt[15] = '{3'd7, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 1};

      rst = 1'b1; in_valid = 1'b0; FS = '0; A = '0; B = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.out", out, 16'h0000);
      check("reset.flags", {zero_flag, carry_flag, ovf_flag}, 3'b000);
      check("reset.out_valid", out_valid, 1'b0);
      check("reset.in_ready", in_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++)
         run_and_check($sformatf("vec%0d", i), vt[i].fs, vt[i].a, vt[i].b,
                       vt[i].e_out, vt[i].e_z, vt[i].e_c, vt[i].e_v, vt[i].e_lat);

      // Requests while busy are dropped: exactly one result for SHL 1 by 8.
      FS = 3'd6; A = 16'h0001; B = 16'h0008; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      pulses = 0; got = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            pulses++;
            got = out;
         end
         if (i < 8) check($sformatf("busy.ready_low%0d", i), in_ready, 1'b0);
         in_valid = (i >= 2 && i <= 4);
         FS = 3'd0; A = 16'($urandom); B = 16'($urandom);
      end
      in_valid = 1'b0;
      check("busy.pulses", pulses, 1);
      check("busy.out", got, 16'h0100);

      // Reset on the 5th SHIFT cycle of a 10-bit shift aborts it silently.
      FS = 3'd6; A = 16'h0005; B = 16'h000A; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.out", out, 16'h0000);
      check("abort.flags", {zero_flag, carry_flag, ovf_flag}, 3'b000);
      check("abort.out_valid", out_valid, 1'b0);
      check("abort.in_ready", in_ready, 1'b1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("abort.no_pulse", pulses, 0);
      run_and_check("abort.add", 3'd0, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 1);

      // Reset wins over a simultaneous request.
      rst = 1'b1; in_valid = 1'b1; FS = 3'd0; A = 16'h0001; B = 16'h0001;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check("prio.in_ready", in_ready, 1'b1);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("prio.no_pulse", pulses, 0);

      for (int n = 0; n < 200; n++) begin
         rfs = 3'($urandom_range(0, 7));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if (n % 5 == 0) ra = (n % 10 == 0) ? 16'h8000 : 16'h7FFF;
         ref_model(rfs, ra, rb, e_o, e_z, e_c, e_v, e_lat);
         run_and_check($sformatf("rnd%0d", n), rfs, ra, rb, e_o, e_z, e_c, e_v, e_lat);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
